// File: rtl/ram_bist_pkg.sv
// Shared types and the March C- element table for the RAM BIST engine.
// Each element is described by direction, optional read pattern and optional write pattern.
package ram_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_WAIT,
    ST_CMP,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    ELEM_M0 = 3'd0,
    ELEM_M1 = 3'd1,
    ELEM_M2 = 3'd2,
    ELEM_M3 = 3'd3,
    ELEM_M4 = 3'd4,
    ELEM_M5 = 3'd5
  } elem_t;

  typedef struct packed {
    logic down;
    logic has_read;
    logic rd_one;
    logic has_write;
    logic wr_one;
  } elem_info_t;

  function automatic elem_info_t elem_info(input elem_t e);
    elem_info_t info;
    info = '0;
    case (e)
      ELEM_M0: info = '{down: 1'b0, has_read: 1'b0, rd_one: 1'b0, has_write: 1'b1, wr_one: 1'b0};
      ELEM_M1: info = '{down: 1'b0, has_read: 1'b1, rd_one: 1'b0, has_write: 1'b1, wr_one: 1'b1};
      ELEM_M2: info = '{down: 1'b0, has_read: 1'b1, rd_one: 1'b1, has_write: 1'b1, wr_one: 1'b0};
      ELEM_M3: info = '{down: 1'b1, has_read: 1'b1, rd_one: 1'b0, has_write: 1'b1, wr_one: 1'b1};
      ELEM_M4: info = '{down: 1'b1, has_read: 1'b1, rd_one: 1'b1, has_write: 1'b1, wr_one: 1'b0};
      ELEM_M5: info = '{down: 1'b0, has_read: 1'b1, rd_one: 1'b0, has_write: 1'b0, wr_one: 1'b0};
      default: info = '0;
    endcase
    return info;
  endfunction

  // The final element has no successor; it maps to itself so the lookup stays total.
  function automatic elem_t next_elem(input elem_t e);
    elem_t n;
    case (e)
      ELEM_M0: n = ELEM_M1;
      ELEM_M1: n = ELEM_M2;
      ELEM_M2: n = ELEM_M3;
      ELEM_M3: n = ELEM_M4;
      ELEM_M4: n = ELEM_M5;
      default: n = ELEM_M5;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ram_bist_addr_gen.sv
// Up/down address counter for the march engine: loads the first address of an
// element, steps in the element's direction and flags the element's last address.
module ram_bist_addr_gen #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  load_down,
  input  logic                  step,
  input  logic                  down,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_down ? '1 : '0;
    end else if (step) begin
      addr <= down ? addr - ADDR_WIDTH'(1) : addr + ADDR_WIDTH'(1);
    end
  end

  assign last = down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/ram_march_bist.sv
// March C- built-in self-test initiator: sequences writes/reads over the whole RAM,
// compares read data with the expected pattern and keeps the first failure.
module ram_march_bist
  import ram_bist_pkg::*;
#(
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int RD_LATENCY   = 1,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [DATA_WIDTH-1:0] fail_exp,
  output logic [DATA_WIDTH-1:0] fail_got,
  output logic                  ram_wr_enb,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_rd_enb,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  localparam bit         STOP      = (STOP_ON_FAIL != 0);
  localparam logic [1:0] WAIT_LAST = 2'((RD_LATENCY > 1) ? RD_LATENCY - 2 : 0);

  state_t                  state;
  elem_t                   elem;
  elem_t                   nxt_elem;
  elem_info_t              info;
  elem_info_t              nxt_info;
  logic [1:0]              wait_cnt;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    addr_last;
  logic                    addr_load;
  logic                    addr_load_down;
  logic                    addr_step;
  logic [DATA_WIDTH-1:0]   exp_data;
  logic                    mismatch;

  assign info     = elem_info(elem);
  assign nxt_elem = next_elem(elem);
  assign nxt_info = elem_info(nxt_elem);
  assign exp_data = {DATA_WIDTH{info.rd_one}};
  assign mismatch = (state == ST_CMP) && (ram_rd_data != exp_data);

  assign ram_wr_addr = addr;
  assign ram_rd_addr = addr;
  assign ram_wr_data = {DATA_WIDTH{info.wr_one}};

  // Counter moves after each write, or after a read-only compare; element ends reload it.
  always_comb begin
    addr_load      = 1'b0;
    addr_load_down = 1'b0;
    addr_step      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          addr_load      = 1'b1;
          addr_load_down = elem_info(ELEM_M0).down;
        end
      end
      ST_WR: begin
        if (addr_last) begin
          addr_load      = 1'b1;
          addr_load_down = nxt_info.down;
        end else begin
          addr_step = 1'b1;
        end
      end
      ST_CMP: begin
        if (!(mismatch && STOP) && !info.has_write && !addr_last) addr_step = 1'b1;
      end
      default: ;
    endcase
  end

  ram_bist_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (addr_load),
    .load_down(addr_load_down),
    .step     (addr_step),
    .down     (info.down),
    .addr     (addr),
    .last     (addr_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      elem       <= ELEM_M0;
      wait_cnt   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      fail_addr  <= '0;
      fail_elem  <= '0;
      fail_exp   <= '0;
      fail_got   <= '0;
      ram_wr_enb <= 1'b0;
      ram_rd_enb <= 1'b0;
    end else begin
      done       <= 1'b0;
      ram_wr_enb <= 1'b0;
      ram_rd_enb <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            pass       <= 1'b0;
            fail       <= 1'b0;
            fail_addr  <= '0;
            fail_elem  <= '0;
            fail_exp   <= '0;
            fail_got   <= '0;
            elem       <= ELEM_M0;
            state      <= ST_WR;
            ram_wr_enb <= 1'b1;
          end
        end
        ST_WR: begin
          if (addr_last) begin
            elem <= nxt_elem;
            if (nxt_info.has_read) begin
              state      <= ST_RD;
              ram_rd_enb <= 1'b1;
            end else begin
              state      <= ST_WR;
              ram_wr_enb <= 1'b1;
            end
          end else if (info.has_read) begin
            state      <= ST_RD;
            ram_rd_enb <= 1'b1;
          end else begin
            state      <= ST_WR;
            ram_wr_enb <= 1'b1;
          end
        end
        ST_RD: begin
          wait_cnt <= '0;
          state    <= (RD_LATENCY > 1) ? ST_WAIT : ST_CMP;
        end
        ST_WAIT: begin
          if (wait_cnt == WAIT_LAST) state <= ST_CMP;
          else wait_cnt <= wait_cnt + 2'd1;
        end
        ST_CMP: begin
          if (mismatch && !fail) begin
            fail_addr <= addr;
            fail_elem <= elem;
            fail_exp  <= exp_data;
            fail_got  <= ram_rd_data;
          end
          if (mismatch) fail <= 1'b1;
          if (mismatch && STOP) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= 1'b0;
          end else if (info.has_write) begin
            state      <= ST_WR;
            ram_wr_enb <= 1'b1;
          end else if (addr_last) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= !(fail || mismatch);
          end else begin
            state      <= ST_RD;
            ram_rd_enb <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_march_bist.sv
// Directed bench for ram_march_bist: three instances (defaults with a stuck-at fault
// option, aliasing RAM without stop-on-fail, and two-cycle read latency).
module tb_ram_march_bist;

  logic clk;
  logic rst;
  logic start_v [3];
  logic busy_v  [3];
  logic done_v  [3];

  int checks      = 0;
  int errors      = 0;
  int overlap_cnt = 0;
  int cycles;
  int dones;
  logic fault_a;

  logic       a_busy, a_done, a_pass, a_fail, a_wr_enb, a_rd_enb;
  logic [3:0] a_fail_addr, a_wr_addr, a_rd_addr;
  logic [2:0] a_fail_elem;
  logic [7:0] a_fail_exp, a_fail_got, a_wr_data, a_rd_data;
  logic [7:0] mem_a [16];

  logic       b_busy, b_done, b_pass, b_fail, b_wr_enb, b_rd_enb;
  logic [3:0] b_fail_addr, b_wr_addr, b_rd_addr;
  logic [2:0] b_fail_elem;
  logic [7:0] b_fail_exp, b_fail_got, b_wr_data, b_rd_data;
  logic [7:0] mem_b [16];

  logic       c_busy, c_done, c_pass, c_fail, c_wr_enb, c_rd_enb;
  logic [3:0] c_fail_addr, c_wr_addr, c_rd_addr;
  logic [2:0] c_fail_elem;
  logic [7:0] c_fail_exp, c_fail_got, c_wr_data, c_rd_data, c_stage;
  logic [7:0] mem_c [16];

  logic [44:0] a_all;
  assign a_all = {a_busy, a_done, a_pass, a_fail, a_fail_addr, a_fail_elem, a_fail_exp,
                  a_fail_got, a_wr_enb, a_wr_addr, a_wr_data, a_rd_enb, a_rd_addr};

  assign busy_v[0] = a_busy;
  assign busy_v[1] = b_busy;
  assign busy_v[2] = c_busy;
  assign done_v[0] = a_done;
  assign done_v[1] = b_done;
  assign done_v[2] = c_done;

  ram_march_bist u_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .busy(a_busy), .done(a_done),
    .pass(a_pass), .fail(a_fail), .fail_addr(a_fail_addr), .fail_elem(a_fail_elem),
    .fail_exp(a_fail_exp), .fail_got(a_fail_got), .ram_wr_enb(a_wr_enb),
    .ram_wr_addr(a_wr_addr), .ram_wr_data(a_wr_data), .ram_rd_enb(a_rd_enb),
    .ram_rd_addr(a_rd_addr), .ram_rd_data(a_rd_data)
  );

  ram_march_bist #(.STOP_ON_FAIL(0)) u_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .busy(b_busy), .done(b_done),
    .pass(b_pass), .fail(b_fail), .fail_addr(b_fail_addr), .fail_elem(b_fail_elem),
    .fail_exp(b_fail_exp), .fail_got(b_fail_got), .ram_wr_enb(b_wr_enb),
    .ram_wr_addr(b_wr_addr), .ram_wr_data(b_wr_data), .ram_rd_enb(b_rd_enb),
    .ram_rd_addr(b_rd_addr), .ram_rd_data(b_rd_data)
  );

  ram_march_bist #(.RD_LATENCY(2)) u_c (
    .clk(clk), .rst(rst), .start(start_v[2]), .busy(c_busy), .done(c_done),
    .pass(c_pass), .fail(c_fail), .fail_addr(c_fail_addr), .fail_elem(c_fail_elem),
    .fail_exp(c_fail_exp), .fail_got(c_fail_got), .ram_wr_enb(c_wr_enb),
    .ram_wr_addr(c_wr_addr), .ram_wr_data(c_wr_data), .ram_rd_enb(c_rd_enb),
    .ram_rd_addr(c_rd_addr), .ram_rd_data(c_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM A: one-cycle read, optional stuck-at-1 on bit 3 of address 5.
  always @(posedge clk) begin
    if (a_wr_enb) mem_a[a_wr_addr] <= a_wr_data;
    if (a_rd_enb) a_rd_data <= mem_a[a_rd_addr] | ((fault_a && a_rd_addr == 4'd5) ? 8'h08 : 8'h00);
  end

  // RAM B: address 11 decodes onto the cell of address 3.
  always @(posedge clk) begin
    if (b_wr_enb) mem_b[(b_wr_addr == 4'd11) ? 4'd3 : b_wr_addr] <= b_wr_data;
    if (b_rd_enb) b_rd_data <= mem_b[(b_rd_addr == 4'd11) ? 4'd3 : b_rd_addr];
  end

  // RAM C: two-cycle read pipeline.
  always @(posedge clk) begin
    if (c_wr_enb) mem_c[c_wr_addr] <= c_wr_data;
    if (c_rd_enb) c_stage <= mem_c[c_rd_addr];
    c_rd_data <= c_stage;
  end

  always @(negedge clk) begin
    if ((a_wr_enb && a_rd_enb) || (b_wr_enb && b_rd_enb) || (c_wr_enb && c_rd_enb))
      overlap_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pulses start for one DUT, then counts busy cycles until the done pulse; optional
  // start pulses at given busy-cycle counts and an early exit at abort_at.
  task automatic applyStimulus(input int which, input int pulse1, input int pulse2,
                               input int abort_at, output int n_busy, output int n_done);
    n_busy = 0;
    n_done = 0;
    @(negedge clk) start_v[which] = 1'b1;
    @(negedge clk) start_v[which] = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if (busy_v[which]) n_busy++;
      if (done_v[which]) begin
        n_done++;
        break;
      end
      if (abort_at > 0 && n_busy == abort_at) break;
      start_v[which] = (n_busy == pulse1) || (n_busy == pulse2);
      @(negedge clk);
    end
    start_v[which] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    fault_a = 1'b0;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_outputs", 64'(a_all), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] fault-free run, defaults");
    applyStimulus(0, 0, 0, 0, cycles, dones);
    checkOutput("a_busy_cycles", 64'(cycles), 64'd240);
    checkOutput("a_done_seen", 64'(dones), 64'd1);
    checkOutput("a_pass_fail", 64'({a_pass, a_fail}), 64'b10);
    @(negedge clk);
    checkOutput("a_pass_held_idle", 64'({a_busy, a_pass}), 64'b01);

    $display("[TB] stuck-at-1 addr 5 bit 3, stop on fail");
    fault_a = 1'b1;
    applyStimulus(0, 0, 0, 0, cycles, dones);
    checkOutput("f_busy_cycles", 64'(cycles), 64'd33);
    checkOutput("f_done_seen", 64'(dones), 64'd1);
    checkOutput("f_pass_fail", 64'({a_pass, a_fail}), 64'b01);
    checkOutput("f_capture", 64'({a_fail_elem, a_fail_addr, a_fail_exp, a_fail_got}),
                64'({3'd1, 4'd5, 8'h00, 8'h08}));
    fault_a = 1'b0;

    $display("[TB] aliasing RAM, run to completion");
    applyStimulus(1, 0, 0, 0, cycles, dones);
    checkOutput("b_busy_cycles", 64'(cycles), 64'd240);
    checkOutput("b_done_seen", 64'(dones), 64'd1);
    checkOutput("b_pass_fail", 64'({b_pass, b_fail}), 64'b01);
    checkOutput("b_capture", 64'({b_fail_elem, b_fail_addr, b_fail_exp, b_fail_got}),
                64'({3'd1, 4'd11, 8'h00, 8'hFF}));

    $display("[TB] read latency 2, fault-free");
    applyStimulus(2, 0, 0, 0, cycles, dones);
    checkOutput("c_busy_cycles", 64'(cycles), 64'd320);
    checkOutput("c_pass_fail", 64'({c_pass, c_fail, dones[0]}), 64'b101);

    $display("[TB] reset mid-run");
    applyStimulus(0, 0, 0, 100, cycles, dones);
    checkOutput("r_reached_100", 64'({cycles[7:0], a_busy}), 64'({8'd100, 1'b1}));
    rst = 1'b1;
    #1;
    checkOutput("r_async_zero", 64'(a_all), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    checkOutput("r_idle_after", 64'({a_busy, a_wr_enb, a_rd_enb}), 64'd0);
    applyStimulus(0, 0, 0, 0, cycles, dones);
    checkOutput("r_busy_cycles", 64'(cycles), 64'd240);
    checkOutput("r_pass_fail", 64'({a_pass, a_fail, dones[0]}), 64'b101);

    $display("[TB] start pulses during a run");
    applyStimulus(0, 50, 150, 0, cycles, dones);
    checkOutput("s_busy_cycles", 64'(cycles), 64'd240);
    checkOutput("s_done_seen", 64'(dones), 64'd1);
    dones = 0;
    repeat (3) begin
      @(negedge clk);
      if (a_busy || a_done) dones++;
    end
    checkOutput("s_no_retrigger", 64'(dones), 64'd0);

    checkOutput("no_wr_rd_overlap", 64'(overlap_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_march_bist.md
Name: ram_march_bist

Overview:
- Synthesizable built-in self-test initiator that drives the write and read ports of the single-port-pair RAM.
- Runs a March C- algorithm over the full address space and compares every read against the expected pattern.
- Reports pass/fail with diagnostic capture.
- Sits between the RAM and a test/control register block; the RAM's normal initiator is muxed out while busy (mux is outside this block).

Parameters:
- ADDR_WIDTH, 4, RAM address width; DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, RAM data width.
- RD_LATENCY, 1, cycles from ram_rd_enb to valid ram_rd_data (legal range 1..4).
- STOP_ON_FAIL, 1, 1 = abort on first mismatch; 0 = run to completion, keep first failure.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  level-sampled start request; honoured only in IDLE
- busy  out  1  test in progress
- done  out  1  one-cycle completion pulse
- pass  out  1  result valid and no mismatch; held until next accepted start
- fail  out  1  sticky mismatch flag; cleared on accepted start
- fail_addr  out  ADDR_WIDTH  address of first mismatch
- fail_elem  out  3  march element index (0..5) of first mismatch
- fail_exp  out  DATA_WIDTH  expected data of first mismatch
- fail_got  out  DATA_WIDTH  read data of first mismatch
- ram_wr_enb  out  1  RAM write enable
- ram_wr_addr  out  ADDR_WIDTH  RAM write address
- ram_wr_data  out  DATA_WIDTH  RAM write data
- ram_rd_enb  out  1  RAM read enable
- ram_rd_addr  out  ADDR_WIDTH  RAM read address
- ram_rd_data  in  DATA_WIDTH  RAM read data

Behaviour:
- Reset (async, any time, including mid-test): all outputs 0, FSM to IDLE, address counter 0. No RAM access is issued in the cycle reset deasserts.
- Patterns: "0" = all zeros, "1" = all ones.
- March elements:
  - M0: up, w0
  - M1: up, r0 w1
  - M2: up, r1 w0
  - M3: down, r0 w1
  - M4: down, r1 w0
  - M5: up, r0
- "Up" runs address 0..DEPTH-1; "down" runs DEPTH-1..0.
- FSM states: IDLE, WR, RD, WAIT, CMP, DONE.
  - IDLE: start=1 at an edge -> clear pass/fail/fail_* and set busy=1 on that edge; enter WR (M0, addr 0).
  - WR: ram_wr_enb=1 for exactly 1 cycle.
    - After a write, step the address, or advance to the next element's first address and op.
    - M0 needs no read, so it goes WR -> WR.
  - RD: ram_rd_enb=1 for exactly 1 cycle, then WAIT for RD_LATENCY-1 cycles (0 if RD_LATENCY=1), then CMP.
  - CMP: sample ram_rd_data, compare with expected, then go to WR (M1..M4) or to the next address/element (M5).
    - Each CMP cycle occurs RD_LATENCY cycles after its RD cycle.
- Per-address cost:
  - M0: 1 cycle
  - M1..M4: 2+RD_LATENCY cycles
  - M5: 1+RD_LATENCY cycles
  - Total busy cycles = DEPTH*(1 + 4*(2+RD_LATENCY) + (1+RD_LATENCY)); 240 for defaults.
- After the last M5 CMP: enter DONE for one cycle.
  - done=1 and busy=0 in that cycle.
  - pass=!fail from that cycle onward.
  - Then return to IDLE.
- Mismatch:
  - First mismatch only: set fail and capture fail_addr, fail_elem, fail_exp, fail_got.
  - Later mismatches do not overwrite the capture.
  - If STOP_ON_FAIL=1, the next state is DONE (done pulse, pass=0), with no further RAM access.
- Never assert ram_wr_enb and ram_rd_enb in the same cycle.
- Drive ram_wr_addr/ram_rd_addr from the same counter; both enables are 0 outside WR/RD.
- start while busy or in DONE is ignored.
- start held high re-triggers one cycle after the DONE cycle (i.e. from IDLE).
- Address counter wraps only at element boundaries; no overflow carries into the element index.

Decomposition:
- ram_bist_pkg holds:
  - FSM state enum
  - march element enum / index type
  - per-element constant table: direction, has_read, read pattern, has_write, write pattern
  - PAT0/PAT1 generation via DATA_WIDTH replication in the module
- One sub-module, ram_bist_addr_gen:
  - up/down counter with load-first, step, and last-address flag
  - driven by element direction

Test Plan:
- Fault-free RAM model, defaults, start pulse -> busy for 240 cycles, done pulse at cycle 241, pass=1, fail=0, no simultaneous wr/rd enables.
- RAM model with addr 5 bit 3 stuck-at-1 -> fail=1, fail_elem=1, fail_addr=5, fail_exp=0x00, fail_got=0x08; done follows immediately (STOP_ON_FAIL=1); pass=0.
- Address aliasing model (addr 11 maps to addr 3 cell), STOP_ON_FAIL=0 -> first capture is fail_elem=1, fail_addr=11, fail_exp=0x00, fail_got=0xFF; run completes in 240 cycles; capture unchanged at done.
- RD_LATENCY=2, fault-free -> busy exactly 320 cycles, every CMP two cycles after its RD, pass=1.
- Assert rst at cycle 100 of a run -> all outputs 0 immediately (async); start pulse after release -> full 240-cycle run, pass=1.
- Pulse start at cycles 50 and 150 during a run -> ignored; single done at cycle 241.
